// File: rtl/cpu_irq_remap_ctrl_if.sv
// uP (pi) register bus between the PicoBlaze port decoder and the
// interrupt / remap controller. The master drives address, strobes and
// write data; the slave returns registered read data.
interface cpu_irq_remap_ctrl_if;
    logic       pi_blk_sel;
    logic [3:0] pi_addr;
    logic       pi_wr_en;
    logic       pi_rd_en;
    logic [7:0] pi_wr_data;
    logic [7:0] pi_rd_data;

    modport master (
        output pi_blk_sel,
        output pi_addr,
        output pi_wr_en,
        output pi_rd_en,
        output pi_wr_data,
        input  pi_rd_data
    );

    modport slave (
        input  pi_blk_sel,
        input  pi_addr,
        input  pi_wr_en,
        input  pi_rd_en,
        input  pi_wr_data,
        output pi_rd_data
    );
endinterface

// File: rtl/cpu_irq_remap_ctrl.sv
// Interrupt and remap-reset controller for the PicoBlaze subsystem.
// NUM_IRQ sources with per-source enable, level/edge mode and sticky
// pending bits behind the pi register bus, plus a sequencer that holds the
// CPU in reset for RESET_HOLD cycles around every program-memory remap.
// Optional feature macro CPU_IRQ_VECTOR_EN: adds the VECTOR register, the
// lowest-index priority capture on interrupt_ack and the ack-clear of the
// captured edge-mode pending bit. Without it, address 0x3 reads 0x00 and
// interrupt_ack only masks the interrupt line for one cycle.
module cpu_irq_remap_ctrl #(
    parameter int NUM_IRQ    = 3,
    parameter int RESET_HOLD = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_IRQ-1:0]   irq_src,
    output logic                 interrupt,
    input  logic                 interrupt_ack,
    cpu_irq_remap_ctrl_if.slave  pi,
    input  logic                 remap,
    output logic                 remap_out,
    output logic                 reset_over_remap
);

    localparam logic [3:0] ADDR_PENDING = 4'h0;
    localparam logic [3:0] ADDR_ENABLE  = 4'h1;
    localparam logic [3:0] ADDR_MODE    = 4'h2;
    localparam logic [3:0] ADDR_VECTOR  = 4'h3;
    localparam logic [3:0] ADDR_RAW     = 4'h4;

    // Bits at and above NUM_IRQ are held at zero so they read 0 and ignore
    // writes; the constant-zero flops are trimmed by synthesis.
    localparam logic [7:0] IRQ_MASK  = 8'((1 << NUM_IRQ) - 1);
    localparam logic [3:0] HOLD_LOAD = 4'(RESET_HOLD - 1);

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_t;

    state_t     state;
    state_t     state_d;
    logic [3:0] cnt;
    logic [3:0] cnt_d;
    logic       ror_d;
    logic       remap_out_d;
    logic       remap_prev;
    logic       remap_evt;

    logic [7:0] irq_q;
    logic [7:0] irq_q_prev;
    logic [7:0] irq_edge;
    logic [7:0] pending;
    logic [7:0] pending_d;
    logic [7:0] enable;
    logic [7:0] mode;
    logic [7:0] irq_active;
    logic [7:0] w1c_mask;
    logic [7:0] ack_clr;
    logic [7:0] rd_mux;
    logic       wr_sel;
    logic       rd_sel;

    assign wr_sel     = pi.pi_blk_sel & pi.pi_wr_en;
    assign rd_sel     = pi.pi_blk_sel & pi.pi_rd_en;
    assign irq_edge   = irq_q & ~irq_q_prev;
    assign irq_active = pending & enable;
    assign w1c_mask   = (wr_sel && (pi.pi_addr == ADDR_PENDING)) ? pi.pi_wr_data : 8'h00;
    assign remap_evt  = remap ^ remap_prev;

    // Single synchroniser stage on the request lines plus the previous sample
    // used for rising-edge detection; pure data, so no reset needed.
    always_ff @(posedge clk) begin
        irq_q      <= 8'(irq_src);
        irq_q_prev <= irq_q;
    end

    // remap_prev follows remap even during reset so no event fires on exit.
    always_ff @(posedge clk) begin
        remap_prev <= remap;
    end

`ifdef CPU_IRQ_VECTOR_EN
    logic [7:0] vector;
    logic [2:0] ack_id;

    // Lowest set index wins; returns 0 for an all-zero input, the caller
    // decides validity separately.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] id;
        id = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                id = 3'(i);
            end
        end
        return id;
    endfunction

    // Priority encode the active sources for capture on acknowledge.
    always_comb begin
        ack_id = lowest_set(irq_active);
    end

    // Acknowledge retires the captured source only; mode is applied later.
    always_comb begin
        ack_clr = 8'h00;
        for (int i = 0; i < 8; i++) begin
            ack_clr[i] = interrupt_ack && irq_active[i] && (ack_id == 3'(i));
        end
    end

    // VECTOR captures {valid, id} on each acknowledge, 0x00 when nothing active.
    always_ff @(posedge clk) begin
        if (reset) begin
            vector <= 8'h00;
        end else if (interrupt_ack) begin
            vector <= (|irq_active) ? {5'b10000, ack_id} : 8'h00;
        end
    end
`else
    // Without the vector feature the acknowledge never clears pending bits.
    always_comb begin
        ack_clr = 8'h00;
    end
`endif

    // Per-bit pending update: the remap hold wipes everything; level bits
    // mirror the sample; edge bits give a new edge priority over any clear.
    always_comb begin
        pending_d = pending;
        for (int i = 0; i < 8; i++) begin
            if (state == ST_HOLD) begin
                pending_d[i] = 1'b0;
            end else if (!mode[i]) begin
                pending_d[i] = irq_q[i];
            end else if (irq_edge[i]) begin
                pending_d[i] = 1'b1;
            end else if (w1c_mask[i] || ack_clr[i]) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    // Register read mux; unmapped addresses and absent registers read 0x00.
    always_comb begin
        rd_mux = 8'h00;
        case (pi.pi_addr)
            ADDR_PENDING: rd_mux = pending;
            ADDR_ENABLE:  rd_mux = enable;
            ADDR_MODE:    rd_mux = mode;
`ifdef CPU_IRQ_VECTOR_EN
            ADDR_VECTOR:  rd_mux = vector;
`endif
            ADDR_RAW:     rd_mux = irq_q;
            default:      rd_mux = 8'h00;
        endcase
    end

    // Register file, registered read port and the interrupt line. The line is
    // gated by the acknowledge (one-cycle mask) and by the next value of the
    // remap reset so it is never high while the CPU is held in reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending       <= 8'h00;
            enable        <= IRQ_MASK;
            mode          <= 8'h00;
            interrupt     <= 1'b0;
            pi.pi_rd_data <= 8'h00;
        end else begin
            pending       <= pending_d & IRQ_MASK;
            interrupt     <= (|irq_active) && !interrupt_ack && !ror_d;
            pi.pi_rd_data <= rd_sel ? rd_mux : 8'h00;
            if (wr_sel && (pi.pi_addr == ADDR_ENABLE)) begin
                enable <= pi.pi_wr_data & IRQ_MASK;
            end
            if (wr_sel && (pi.pi_addr == ADDR_MODE)) begin
                mode <= pi.pi_wr_data & IRQ_MASK;
            end
        end
    end

    // Remap sequencer state register; remap_out tracks remap while in reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            cnt              <= 4'd0;
            reset_over_remap <= 1'b0;
            remap_out        <= remap;
        end else begin
            state            <= state_d;
            cnt              <= cnt_d;
            reset_over_remap <= ror_d;
            remap_out        <= remap_out_d;
        end
    end

    // Remap sequencer next state: any event (re)loads the hold counter, and
    // the new remap level is passed on only as the hold expires.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        ror_d       = reset_over_remap;
        remap_out_d = remap_out;
        case (state)
            ST_IDLE: begin
                if (remap_evt) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                    ror_d   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (remap_evt) begin
                    cnt_d = HOLD_LOAD;
                end else if (cnt == 4'd0) begin
                    state_d     = ST_IDLE;
                    ror_d       = 1'b0;
                    remap_out_d = remap;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ror_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_irq_remap_ctrl.sv
// Bench for cpu_irq_remap_ctrl: directed scenarios followed by random
// traffic, every cycle compared against a behavioural reference model.
module tb_cpu_irq_remap_ctrl;

    localparam int NUM_IRQ    = 3;
    localparam int RESET_HOLD = 5;
`ifdef CPU_IRQ_VECTOR_EN
    localparam bit VEC_EN = 1'b1;
`else
    localparam bit VEC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] irq_src;
    logic       interrupt;
    logic       interrupt_ack;
    logic       remap;
    logic       remap_out;
    logic       reset_over_remap;

    cpu_irq_remap_ctrl_if pi_bus ();

    cpu_irq_remap_ctrl #(
        .NUM_IRQ   (NUM_IRQ),
        .RESET_HOLD(RESET_HOLD)
    ) dut (
        .clk             (clk),
        .reset           (rst),
        .irq_src         (irq_src),
        .interrupt       (interrupt),
        .interrupt_ack   (interrupt_ack),
        .pi              (pi_bus),
        .remap           (remap),
        .remap_out       (remap_out),
        .reset_over_remap(reset_over_remap)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] m_q, m_prev, m_pend, m_en, m_mode, m_vec, m_rd;
    logic       m_int, m_rout, m_rprev;
    int         m_left;   // remaining CPU-reset cycles, 0 when not holding

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        logic [7:0] pe, w1c, aclr, np, nrd, nen, nmode, nvec;
        int         ack_id;
        int         nleft;
        logic       nrout;
        if (rst) begin
            m_pend = 8'h00; m_en = 8'h07; m_mode = 8'h00; m_vec = 8'h00;
            m_int  = 1'b0;  m_rd = 8'h00; m_left = 0;     m_rout = remap;
        end else begin
            pe     = m_pend & m_en;
            ack_id = -1;
            for (int i = 0; i < NUM_IRQ; i++) if (pe[i] && ack_id < 0) ack_id = i;
            w1c  = (pi_bus.pi_blk_sel && pi_bus.pi_wr_en && pi_bus.pi_addr == 4'h0)
                   ? pi_bus.pi_wr_data : 8'h00;
            aclr = (VEC_EN && interrupt_ack && ack_id >= 0) ? 8'(1 << ack_id) : 8'h00;
            if (m_left > 0) np = 8'h00;
            else np = ((((m_q & ~m_prev) | (m_pend & ~(w1c | aclr))) & m_mode)
                      | (m_q & ~m_mode)) & 8'h07;
            nrd = 8'h00;
            if (pi_bus.pi_blk_sel && pi_bus.pi_rd_en) begin
                case (pi_bus.pi_addr)
                    4'h0: nrd = m_pend;
                    4'h1: nrd = m_en;
                    4'h2: nrd = m_mode;
                    4'h3: nrd = VEC_EN ? m_vec : 8'h00;
                    4'h4: nrd = m_q;
                    default: nrd = 8'h00;
                endcase
            end
            nen   = m_en;
            nmode = m_mode;
            if (pi_bus.pi_blk_sel && pi_bus.pi_wr_en && pi_bus.pi_addr == 4'h1) nen = pi_bus.pi_wr_data & 8'h07;
            if (pi_bus.pi_blk_sel && pi_bus.pi_wr_en && pi_bus.pi_addr == 4'h2) nmode = pi_bus.pi_wr_data & 8'h07;
            nvec = m_vec;
            if (VEC_EN && interrupt_ack) nvec = (ack_id >= 0) ? (8'h80 | 8'(ack_id)) : 8'h00;
            nleft = m_left;
            nrout = m_rout;
            if (remap != m_rprev) nleft = RESET_HOLD;
            else if (m_left > 0) begin
                nleft = m_left - 1;
                if (nleft == 0) nrout = remap;
            end
            m_int  = !interrupt_ack && (nleft == 0) && (pe != 8'h00);
            m_pend = np; m_rd = nrd; m_en = nen; m_mode = nmode; m_vec = nvec;
            m_left = nleft; m_rout = nrout;
        end
        m_prev  = m_q;
        m_q     = {5'd0, irq_src};
        m_rprev = remap;
    endtask

    // One clock: update model at the edge, compare all outputs 1 ns later.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("interrupt", {7'd0, interrupt}, {7'd0, m_int});
        chk("reset_over_remap", {7'd0, reset_over_remap}, {7'd0, (m_left > 0)});
        chk("remap_out", {7'd0, remap_out}, {7'd0, m_rout});
        chk("pi_rd_data", pi_bus.pi_rd_data, m_rd);
    endtask

    task automatic pi_write(input logic [3:0] a, input logic [7:0] d);
        pi_bus.pi_blk_sel = 1'b1; pi_bus.pi_wr_en = 1'b1;
        pi_bus.pi_addr = a; pi_bus.pi_wr_data = d;
        cyc();
        pi_bus.pi_blk_sel = 1'b0; pi_bus.pi_wr_en = 1'b0;
    endtask

    task automatic pi_read(input logic [3:0] a, output logic [7:0] d);
        pi_bus.pi_blk_sel = 1'b1; pi_bus.pi_rd_en = 1'b1; pi_bus.pi_addr = a;
        cyc();
        d = pi_bus.pi_rd_data;
        pi_bus.pi_blk_sel = 1'b0; pi_bus.pi_rd_en = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        m_q = 8'h00; m_prev = 8'h00; m_pend = 8'h00; m_en = 8'h07; m_mode = 8'h00;
        m_vec = 8'h00; m_rd = 8'h00; m_int = 1'b0; m_rout = 1'b0; m_rprev = 1'b0; m_left = 0;
        rst = 1'b1; irq_src = 3'b000; interrupt_ack = 1'b0; remap = 1'b0;
        pi_bus.pi_blk_sel = 1'b0; pi_bus.pi_addr = 4'h0; pi_bus.pi_wr_en = 1'b0;
        pi_bus.pi_rd_en = 1'b0; pi_bus.pi_wr_data = 8'h00;
        repeat (3) cyc();
        rst = 1'b0;

        // Reset state
        pi_read(4'h1, d); chk("enable_reset", d, 8'h07);
        pi_read(4'h0, d); chk("pending_reset", d, 8'h00);
        pi_read(4'h3, d); chk("vector_reset", d, 8'h00);
        chk("interrupt_reset", {7'd0, interrupt}, 8'h00);

        // Edge source 1, one-cycle pulse, then W1C
        pi_write(4'h2, 8'h02);
        irq_src = 3'b010; cyc();
        irq_src = 3'b000; cyc();
        chk("int_before_3cyc", {7'd0, interrupt}, 8'h00);
        cyc();
        chk("int_after_3cyc", {7'd0, interrupt}, 8'h01);
        pi_read(4'h0, d); chk("pending_edge1", d, 8'h02);
        pi_write(4'h0, 8'h02);
        cyc();
        chk("int_after_w1c", {7'd0, interrupt}, 8'h00);
        pi_read(4'h0, d); chk("pending_after_w1c", d, 8'h00);

        // Simultaneous edges on sources 2 and 1, acknowledged twice
        pi_write(4'h2, 8'h06);
        irq_src = 3'b110; cyc();
        irq_src = 3'b000; cyc(); cyc();
        interrupt_ack = 1'b1; cyc(); interrupt_ack = 1'b0;
        chk("int_masked_by_ack", {7'd0, interrupt}, 8'h00);
        pi_read(4'h3, d); chk("vector_first_ack", d, VEC_EN ? 8'h81 : 8'h00);
        chk("int_reassert", {7'd0, interrupt}, 8'h01);
        pi_read(4'h0, d); chk("pending_after_ack", d, VEC_EN ? 8'h04 : 8'h06);
        interrupt_ack = 1'b1; cyc(); interrupt_ack = 1'b0;
        pi_read(4'h3, d); chk("vector_second_ack", d, VEC_EN ? 8'h82 : 8'h00);
        pi_write(4'h0, 8'h07);
        cyc(); cyc();

        // Level source 0 against ENABLE
        pi_write(4'h2, 8'h00);
        irq_src = 3'b001;
        pi_write(4'h1, 8'h00);
        cyc(); cyc(); cyc();
        chk("level_disabled", {7'd0, interrupt}, 8'h00);
        pi_write(4'h1, 8'h01);
        cyc();
        chk("level_enabled", {7'd0, interrupt}, 8'h01);
        pi_write(4'h0, 8'h01);
        pi_read(4'h0, d); chk("level_w1c_ignored", d, 8'h01);
        irq_src = 3'b000;
        pi_write(4'h1, 8'h07);
        cyc(); cyc();

        // Remap event with edges arriving during the hold
        pi_write(4'h2, 8'h06);
        cyc();
        remap = 1'b1; cyc();
        chk("ror_n1", {7'd0, reset_over_remap}, 8'h01);
        irq_src = 3'b110;
        for (int k = 2; k <= 5; k++) begin
            cyc();
            chk("ror_hold", {7'd0, reset_over_remap}, 8'h01);
            chk("rout_hold", {7'd0, remap_out}, 8'h00);
        end
        cyc();
        chk("ror_fall", {7'd0, reset_over_remap}, 8'h00);
        chk("rout_switch", {7'd0, remap_out}, 8'h01);
        pi_read(4'h0, d); chk("pending_after_hold", d, 8'h00);
        irq_src = 3'b000;
        cyc(); cyc();

        // Second toggle at N+3 extends the hold to N+8
        remap = 1'b0; cyc(); cyc(); cyc();
        remap = 1'b1;
        for (int k = 4; k <= 8; k++) begin
            cyc();
            chk("ror_extended", {7'd0, reset_over_remap}, 8'h01);
            chk("rout_extended", {7'd0, remap_out}, 8'h01);
        end
        cyc();
        chk("ror_ext_fall", {7'd0, reset_over_remap}, 8'h00);
        chk("rout_ext_final", {7'd0, remap_out}, 8'h01);

        // Random traffic against the model
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 3) == 0) irq_src = 3'($urandom);
            interrupt_ack = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 19) == 0) remap = ~remap;
            pi_bus.pi_blk_sel  = ($urandom_range(0, 3) != 0);
            pi_bus.pi_wr_en    = ($urandom_range(0, 3) == 0);
            pi_bus.pi_rd_en    = ($urandom_range(0, 2) == 0);
            pi_bus.pi_addr     = 4'($urandom_range(0, 7));
            pi_bus.pi_wr_data  = 8'($urandom);
            cyc();
        end
        interrupt_ack = 1'b0;
        pi_bus.pi_blk_sel = 1'b0; pi_bus.pi_wr_en = 1'b0; pi_bus.pi_rd_en = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
